// File: rtl/fetch_responder.sv
// Instruction-memory responder for the pipeline fetch port.
// Accepts a fetch request, waits WAIT_STATES cycles, reads the instruction
// array (or substitutes NOP_INSTR on a misaligned/out-of-range address) and
// holds the registered word with instr_ready high until the next request.
// A side-band program port writes the array independently of the FSM.
module fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        read_instr,
  output logic [31:0] instr,
  output logic        instr_ready,
  output logic        fetch_fault,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] instr_q;
  logic        fault_q;

  // Instruction storage; contents survive reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  // Read-side controls produced by the next-state logic.
  logic          do_read;
  logic [31:0]   rd_addr;
  logic          rd_fault;
  logic [AW-1:0] rd_idx;

  // Program-port decode; the byte-offset bits carry no meaning for a word write.
  logic          prog_in_range;
  logic [AW-1:0] prog_idx;
  logic          prog_addr_unused;

  assign prog_in_range    = ({2'b00, prog_addr[31:2]} < 32'(DEPTH_WORDS));
  assign prog_idx         = prog_addr[AW+1:2];
  assign prog_addr_unused = ^prog_addr[1:0];

  // A fetch faults on a misaligned byte address or a word index beyond the array.
  assign rd_fault = (rd_addr[1:0] != 2'b00) ||
                    ({2'b00, rd_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign rd_idx   = rd_addr[AW+1:2];

  // Next-state logic: accept in IDLE/DONE, count waits in BUSY, read in READ.
  // With no wait states the read happens on the accepting edge itself.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    do_read = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (read_instr) begin
          addr_d = pc_addr;
          if (WAIT_STATES == 0) begin
            do_read = 1'b1;
            rd_addr = pc_addr;
            state_d = S_DONE;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // New requests are ignored here; the counter hitting zero moves to READ.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        do_read = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM registers plus the registered response word and fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      cnt_q   <= 4'd0;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      if (do_read) begin
        instr_q <= rd_fault ? NOP_INSTR : mem_q[rd_idx];
        fault_q <= rd_fault;
      end
    end
  end

  // Program writes; reset wins over a simultaneous write, out-of-range writes drop.
  // A same-edge read of the written word sees the previous contents.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && prog_in_range) begin
      mem_q[prog_idx] <= prog_data;
    end
  end

  assign instr       = instr_q;
  assign instr_ready = (state_q == S_DONE);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: three instances (0, 1 and 3 wait states) driven
// with directed and random fetches, checked against a shadow program memory
// and the fault/latency rules of the block.
module tb_fetch_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [3];
  logic [31:0] pc_addr     [3];
  logic        read_instr  [3];
  logic [31:0] instr       [3];
  logic        instr_ready [3];
  logic        fetch_fault [3];
  logic        prog_we     [3];
  logic [31:0] prog_addr   [3];
  logic [31:0] prog_data   [3];

  // Shadow of each instance's program memory.
  logic [31:0] ref_mem [3][DEPTH];

  int checks = 0;
  int errors = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      fetch_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 1 : 3)),
        .NOP_INSTR  (NOP)
      ) u_dut (
        .clk        (clk),
        .rst        (rst[gi]),
        .pc_addr    (pc_addr[gi]),
        .read_instr (read_instr[gi]),
        .instr      (instr[gi]),
        .instr_ready(instr_ready[gi]),
        .fetch_fault(fetch_fault[gi]),
        .prog_we    (prog_we[gi]),
        .prog_addr  (prog_addr[gi]),
        .prog_data  (prog_data[gi])
      );
    end
  endgenerate

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // Edges after the accepting edge until the response is visible.
  function automatic int model_latency(input int k);
    return (ws_of(k) == 0) ? 0 : ws_of(k) + 1;
  endfunction

  function automatic bit model_fault(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
    if (model_fault(a)) return NOP;
    return ref_mem[k][a / 32'd4];
  endfunction

  task automatic prog(input int k, input logic [31:0] a, input logic [31:0] d);
    prog_we[k]   = 1'b1;
    prog_addr[k] = a;
    prog_data[k] = d;
    @(posedge clk); #1;
    prog_we[k] = 1'b0;
    if ((a / 32'd4) < 32'(DEPTH)) ref_mem[k][a / 32'd4] = d;
    $display("PROG  dut%0d addr=%h data=%h", k, a, d);
  endtask

  // Issue one request and count edges until instr_ready is seen (bounded).
  task automatic req(input int k, input logic [31:0] a, output int lat);
    pc_addr[k]    = a;
    read_instr[k] = 1'b1;
    @(posedge clk); #1;
    read_instr[k] = 1'b0;
    pc_addr[k]    = $urandom;
    lat = 0;
    if (ws_of(k) != 0) begin
      while (instr_ready[k] !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    $display("FETCH dut%0d pc=%h instr=%h fault=%b ready=%b lat=%0d",
             k, a, instr[k], fetch_fault[k], instr_ready[k], lat);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; read_instr[k] = 1'b0; prog_we[k] = 1'b0;
      pc_addr[k] = 32'd0; prog_addr[k] = 32'd0; prog_data[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (instr[k] !== NOP) begin
        errors++; $display("FAIL reset_instr dut%0d got=%h exp=%h", k, instr[k], NOP);
      end
      checks++;
      if (instr_ready[k] !== 1'b0) begin
        errors++; $display("FAIL reset_ready dut%0d got=%b exp=0", k, instr_ready[k]);
      end
      checks++;
      if (fetch_fault[k] !== 1'b0) begin
        errors++; $display("FAIL reset_fault dut%0d got=%b exp=0", k, fetch_fault[k]);
      end
      rst[k] = 1'b0;
    end
    $display("RESET all instances released");
  endtask

  task automatic test_basic();
    int lat;
    prog(1, 32'h10, 32'h0050_0093);
    req(1, 32'h10, lat);
    checks++;
    if (lat != model_latency(1)) begin
      errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, model_latency(1));
    end
    checks++;
    if (instr[1] !== model_word(1, 32'h10)) begin
      errors++; $display("FAIL basic_instr got=%h exp=%h", instr[1], model_word(1, 32'h10));
    end
    checks++;
    if (fetch_fault[1] !== 1'b0) begin
      errors++; $display("FAIL basic_fault got=%b exp=0", fetch_fault[1]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_w;
    exp_w = model_word(1, 32'h10);
    for (int i = 0; i < 5; i++) begin
      pc_addr[1]    = $urandom;
      read_instr[1] = 1'b0;
      @(posedge clk); #1;
      $display("STALL dut1 cycle=%0d instr=%h ready=%b", i, instr[1], instr_ready[1]);
      checks++;
      if (instr[1] !== exp_w || instr_ready[1] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got=%h/%b exp=%h/1", i, instr[1], instr_ready[1], exp_w);
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    int lat;
    prog(1, 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D);
    addrs[0] = 32'h6;
    addrs[1] = 32'(4 * DEPTH);
    addrs[2] = 32'(4 * (DEPTH - 1));
    addrs[3] = 32'h10;
    for (int i = 0; i < 4; i++) begin
      req(1, addrs[i], lat);
      checks++;
      if (instr[1] !== model_word(1, addrs[i]) || fetch_fault[1] !== model_fault(addrs[i])) begin
        errors++;
        $display("FAIL fault_resp pc=%h got=%h/%b exp=%h/%b", addrs[i], instr[1],
                 fetch_fault[1], model_word(1, addrs[i]), model_fault(addrs[i]));
      end
      checks++;
      if (lat != model_latency(1)) begin
        errors++; $display("FAIL fault_latency pc=%h got=%0d exp=%0d", addrs[i], lat, model_latency(1));
      end
    end
  endtask

  task automatic test_random(input int k);
    int          idx [8];
    logic [31:0] a;
    int          lat;
    int          mode;
    for (int i = 0; i < 8; i++) begin
      idx[i] = $urandom_range(0, 63);
      prog(k, 32'(idx[i] * 4), $urandom);
    end
    for (int t = 0; t < 20; t++) begin
      mode = $urandom_range(0, 3);
      a = 32'(idx[$urandom_range(0, 7)] * 4);
      if (mode == 0) a = a | 32'($urandom_range(1, 3));
      else if (mode == 1) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
      req(k, a, lat);
      checks++;
      if (instr[k] !== model_word(k, a) || fetch_fault[k] !== model_fault(a) ||
          instr_ready[k] !== 1'b1 || lat != model_latency(k)) begin
        errors++;
        $display("FAIL random dut%0d pc=%h got=%h/%b/%b lat=%0d exp=%h/%b/1 lat=%0d",
                 k, a, instr[k], fetch_fault[k], instr_ready[k], lat,
                 model_word(k, a), model_fault(a), model_latency(k));
      end
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 8; i++) prog(0, 32'(i * 4), 32'(i + 32'h100));
    pc_addr[0]    = 32'h0;
    read_instr[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      $display("SWEEP dut0 pc=%h instr=%h ready=%b", 32'(i * 4), instr[0], instr_ready[0]);
      checks++;
      if (instr[0] !== model_word(0, 32'(i * 4)) || instr_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL throughput i=%0d got=%h/%b exp=%h/1", i, instr[0], instr_ready[0],
                 model_word(0, 32'(i * 4)));
      end
      if (i < 7) pc_addr[0] = 32'((i + 1) * 4);
      else read_instr[0] = 1'b0;
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_old;
    int lat;
    prog(0, 32'hC, 32'hAAAA_0000);
    exp_old       = model_word(0, 32'hC);
    prog_we[0]    = 1'b1;
    prog_addr[0]  = 32'hC;
    prog_data[0]  = 32'h5555_0000;
    pc_addr[0]    = 32'hC;
    read_instr[0] = 1'b1;
    @(posedge clk); #1;
    prog_we[0]    = 1'b0;
    read_instr[0] = 1'b0;
    ref_mem[0][3] = 32'h5555_0000;
    $display("COLL  dut0 pc=0000000c instr=%h", instr[0]);
    checks++;
    if (instr[0] !== exp_old) begin
      errors++; $display("FAIL collision_old got=%h exp=%h", instr[0], exp_old);
    end
    // Out-of-range write whose low index bits alias word 3 must be dropped.
    prog(0, 32'(4 * DEPTH + 12), 32'h0BAD_0BAD);
    req(0, 32'hC, lat);
    checks++;
    if (instr[0] !== model_word(0, 32'hC) || fetch_fault[0] !== 1'b0) begin
      errors++;
      $display("FAIL collision_new got=%h/%b exp=%h/0", instr[0], fetch_fault[0], model_word(0, 32'hC));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit saw_ready;
    int lat;
    prog(2, 32'h10, 32'h00A0_0113);
    pc_addr[2]    = 32'h10;
    read_instr[2] = 1'b1;
    @(posedge clk); #1;
    read_instr[2] = 1'b0;
    @(posedge clk); #1;
    // Second BUSY cycle: reset, with a program write that must be dropped.
    rst[2]       = 1'b1;
    prog_we[2]   = 1'b1;
    prog_addr[2] = 32'h10;
    prog_data[2] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst[2]     = 1'b0;
    prog_we[2] = 1'b0;
    saw_ready  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (instr_ready[2] !== 1'b0) saw_ready = 1'b1;
      @(posedge clk); #1;
    end
    $display("ABORT dut2 saw_ready=%b instr=%h", saw_ready, instr[2]);
    checks++;
    if (saw_ready || instr[2] !== NOP || fetch_fault[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort got=ready_seen:%b instr:%h fault:%b exp=ready_seen:0 instr:%h fault:0",
               saw_ready, instr[2], fetch_fault[2], NOP);
    end
    req(2, 32'h10, lat);
    checks++;
    if (lat != model_latency(2) || instr[2] !== model_word(2, 32'h10)) begin
      errors++;
      $display("FAIL after_abort got=%h lat=%0d exp=%h lat=%0d", instr[2], lat,
               model_word(2, 32'h10), model_latency(2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_faults();
    test_random(1);
    test_random(2);
    test_throughput();
    test_collision();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
